// File: rtl/voting_machine_param.sv
// Parameterised voting machine: hold-qualified single-button votes,
// saturating per-candidate counters, running total and winner/tie flags.
module voting_machine_param #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 10,
    parameter int ACK_CYCLES  = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                mode,
    input  logic [NUM_CAND-1:0]                 buttons,
    output logic [CNT_W-1:0]                    led,
    output logic                                vote_valid,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0]   total,
    output logic [$clog2(NUM_CAND)-1:0]         winner,
    output logic                                tie,
    output logic                                sat
);

    localparam int IDX_W = $clog2(NUM_CAND);
    localparam int TOT_W = CNT_W + IDX_W;
    localparam int HW    = $clog2(HOLD_CYCLES + 1);
    localparam int AW    = $clog2(ACK_CYCLES + 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ARM      = 2'd1;
    localparam logic [1:0] WAIT_REL = 2'd2;

    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_sel;
    logic [HW-1:0]       r_hold;
    logic [AW-1:0]       r_ack;
    logic [CNT_W-1:0]    r_cnt [NUM_CAND];
    logic                r_need_rel;
    logic                r_vote;
    logic                r_sat;
    logic [CNT_W-1:0]    r_led;
    logic [TOT_W-1:0]    r_total;
    logic [IDX_W-1:0]    r_winner;
    logic                r_tie;

    logic                w_any;
    logic                w_one_hot;
    logic [IDX_W-1:0]    w_idx;
    logic [NUM_CAND-1:0] w_sel_pat;
    logic                w_commit;
    logic [AW-1:0]       w_ack_nxt;
    logic [TOT_W-1:0]    w_total;
    logic [CNT_W-1:0]    w_max;
    logic [IDX_W-1:0]    w_win;
    logic                w_seen;
    logic                w_tie;

    assign w_any     = |buttons;
    assign w_one_hot = w_any && ((buttons & (buttons - 1'b1)) == '0);
    assign w_sel_pat = NUM_CAND'(1) << r_sel;
    assign w_commit  = (r_state == ARM) && !mode && (buttons == w_sel_pat)
                    && (r_hold == HW'(HOLD_CYCLES - 1));

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_CAND; i++)
            if (buttons[i]) w_idx = IDX_W'(i);
    end

    always_comb begin
        w_ack_nxt = r_ack;
        if (mode)
            w_ack_nxt = '0;
        else if (w_commit)
            w_ack_nxt = AW'(ACK_CYCLES);
        else if (r_ack != '0)
            w_ack_nxt = r_ack - AW'(1);
    end

    // Strict '>' keeps the lowest index on equal counts
    always_comb begin
        w_total = '0;
        w_max   = '0;
        w_win   = '0;
        w_seen  = 1'b0;
        w_tie   = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            w_total = w_total + TOT_W'(r_cnt[i]);
            if (r_cnt[i] > w_max) begin
                w_max = r_cnt[i];
                w_win = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_CAND; i++) begin
            if (r_cnt[i] == w_max) begin
                if (w_seen) w_tie = 1'b1;
                w_seen = 1'b1;
            end
        end
        w_tie = w_tie && (w_max != '0);
    end

    // r_need_rel blocks a button still held across reset from arming
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_hold     <= '0;
            r_ack      <= '0;
            r_need_rel <= 1'b1;
            r_vote     <= 1'b0;
            r_sat      <= 1'b0;
            r_led      <= '0;
            r_total    <= '0;
            r_winner   <= '0;
            r_tie      <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) r_cnt[i] <= '0;
        end else begin
            if (!w_any) r_need_rel <= 1'b0;
            r_vote   <= w_commit;
            r_ack    <= w_ack_nxt;
            r_total  <= w_total;
            r_winner <= w_win;
            r_tie    <= w_tie;
            if (mode)
                r_led <= w_one_hot ? r_cnt[w_idx] : '0;
            else
                r_led <= (w_ack_nxt != '0) ? '1 : '0;
            if (w_commit) begin
                if (r_cnt[r_sel] == '1) r_sat <= 1'b1;
                else r_cnt[r_sel] <= r_cnt[r_sel] + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (!mode && w_any) begin
                        if (w_one_hot && !r_need_rel) begin
                            r_sel   <= w_idx;
                            r_hold  <= HW'(1);
                            r_state <= ARM;
                        end else begin
                            r_state <= WAIT_REL;
                        end
                    end
                end
                ARM: begin
                    if (mode || buttons != w_sel_pat || w_commit)
                        r_state <= WAIT_REL;
                    else
                        r_hold <= r_hold + HW'(1);
                end
                WAIT_REL: begin
                    if (!w_any) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign led        = r_led;
    assign vote_valid = r_vote;
    assign total      = r_total;
    assign winner     = r_winner;
    assign tie        = r_tie;
    assign sat        = r_sat;

endmodule

// File: tb/tb_voting_machine_param.sv
// Bench for voting_machine_param: random press sequences against a
// vote-level model, plus an instance with 2-bit counters for saturation.
module tb_voting_machine_param;

    localparam int HOLD = 10;
    localparam int ACK  = 8;

    logic       clock;
    logic       reset;
    logic       mode;
    logic [3:0] buttons;

    logic [7:0] led;
    logic       vote_valid;
    logic [9:0] total;
    logic [1:0] winner;
    logic       tie;
    logic       sat;

    logic [1:0] led2;
    logic       vote_valid2;
    logic [3:0] total2;
    logic [1:0] winner2;
    logic       tie2;
    logic       sat2;

    int n_chk;
    int n_fail;
    int m_cnt  [4];
    int m_cnt2 [4];
    bit m_sat;
    bit m_sat2;

    voting_machine_param #(
        .NUM_CAND(4), .CNT_W(8), .HOLD_CYCLES(HOLD), .ACK_CYCLES(ACK)
    ) u_dut (
        .clock(clock), .reset(reset), .mode(mode), .buttons(buttons),
        .led(led), .vote_valid(vote_valid), .total(total),
        .winner(winner), .tie(tie), .sat(sat)
    );

    voting_machine_param #(
        .NUM_CAND(4), .CNT_W(2), .HOLD_CYCLES(HOLD), .ACK_CYCLES(ACK)
    ) u_sat (
        .clock(clock), .reset(reset), .mode(mode), .buttons(buttons),
        .led(led2), .vote_valid(vote_valid2), .total(total2),
        .winner(winner2), .tie(tie2), .sat(sat2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int first_idx(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return 0;
    endfunction

    task automatic exp_wt(input int c [4], output int w, output bit t,
                          output int tot);
        int mx = 0;
        int n = 0;
        w = 0;
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            tot += c[i];
            if (c[i] > mx) begin mx = c[i]; w = i; end
        end
        for (int i = 0; i < 4; i++) if (c[i] == mx) n++;
        t = (mx > 0) && (n >= 2);
    endtask

    task automatic check_state(input string tag);
        int w, tot;
        bit t;
        exp_wt(m_cnt, w, t, tot);
        chk({tag, ":total"}, 32'(total), 32'(tot));
        chk({tag, ":winner"}, 32'(winner), 32'(w));
        chk({tag, ":tie"}, 32'(tie), 32'(t));
        chk({tag, ":sat"}, 32'(sat), 32'(m_sat));
        exp_wt(m_cnt2, w, t, tot);
        chk({tag, ":total2"}, 32'(total2), 32'(tot));
        chk({tag, ":winner2"}, 32'(winner2), 32'(w));
        chk({tag, ":tie2"}, 32'(tie2), 32'(t));
        chk({tag, ":sat2"}, 32'(sat2), 32'(m_sat2));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 0;
            m_cnt2[i] = 0;
        end
        m_sat  = 1'b0;
        m_sat2 = 1'b0;
    endtask

    // One press of pattern pat for hold edges, then gap edges released
    task automatic do_press(input logic [3:0] pat, input int hold,
                            input bit md, input int gap);
        bit vote = !md && ($countones(pat) == 1) && (hold >= HOLD);
        int idx = first_idx(pat);
        int p1 = 0;
        int p2 = 0;
        int at = -1;
        int ffs = 0;
        int dexp;
        mode    = md;
        buttons = pat;
        for (int k = 1; k <= hold; k++) begin
            tick();
            if (vote_valid) begin p1++; at = k; end
            if (vote_valid2) p2++;
            if (!md && k >= HOLD && led == 8'hFF) ffs++;
            if (md && k == 1) begin
                dexp = ($countones(pat) == 1) ? m_cnt[idx] : 0;
                chk("disp_led", 32'(led), 32'(dexp));
            end
        end
        buttons = '0;
        mode    = 1'b0;
        for (int k = 0; k < gap; k++) begin
            tick();
            if (vote_valid) p1++;
            if (vote_valid2) p2++;
        end
        if (vote) begin
            if (m_cnt[idx] == 255) m_sat = 1'b1;
            else m_cnt[idx]++;
            if (m_cnt2[idx] == 3) m_sat2 = 1'b1;
            else m_cnt2[idx]++;
        end
        chk("pulses", 32'(p1), 32'(vote));
        chk("pulses2", 32'(p2), 32'(vote));
        if (vote) chk("vote_edge", 32'(at), 32'(HOLD));
        if (vote && hold >= HOLD + ACK) chk("ack_len", 32'(ffs), 32'(ACK));
    endtask

    initial begin
        int r, hold, gap, p1;
        bit md;
        logic [3:0] pat;
        n_chk   = 0;
        n_fail  = 0;
        reset   = 1'b1;
        mode    = 1'b0;
        buttons = '0;
        clear_model();
        repeat (10) tick();
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_vv", 32'(vote_valid), 32'd0);
        check_state("rst");
        reset = 1'b0;
        tick();

        do_press(4'b0001, 20, 1'b0, 3);
        check_state("v0");
        do_press(4'b0010, 5, 1'b0, 3);
        do_press(4'b0110, 20, 1'b0, 3);
        check_state("nov");
        do_press(4'b0001, 20, 1'b0, 3);
        do_press(4'b0010, 20, 1'b0, 3);
        do_press(4'b0010, 20, 1'b0, 3);
        check_state("tie");
        do_press(4'b0010, 20, 1'b0, 3);
        check_state("win1");
        do_press(4'b0001, 3, 1'b1, 2);
        do_press(4'b0010, 3, 1'b1, 2);
        do_press(4'b0011, 3, 1'b1, 2);

        // Mode raised mid-hold must abort the vote
        mode = 1'b0;
        buttons = 4'b0100;
        p1 = 0;
        repeat (4) begin tick(); p1 += int'(vote_valid); end
        mode = 1'b1;
        repeat (16) begin tick(); p1 += int'(vote_valid); end
        mode = 1'b0;
        buttons = '0;
        repeat (3) begin tick(); p1 += int'(vote_valid); end
        chk("mode_abort", 32'(p1), 32'd0);
        check_state("mab");

        repeat (5) do_press(4'b1000, 12, 1'b0, 2);
        check_state("sat");

        // Reset mid-hold; the held button must not vote afterwards
        buttons = 4'b0001;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        clear_model();
        chk("arst_led", 32'(led), 32'd0);
        check_state("arst");
        repeat (2) tick();
        reset = 1'b0;
        p1 = 0;
        repeat (20) begin tick(); p1 += int'(vote_valid); end
        buttons = '0;
        repeat (3) begin tick(); p1 += int'(vote_valid); end
        chk("post_rst", 32'(p1), 32'd0);
        check_state("prst");

        for (int n = 0; n < 80; n++) begin
            r    = $urandom_range(0, 9);
            hold = $urandom_range(1, 22);
            gap  = $urandom_range(2, 4);
            md   = 1'b0;
            if (r <= 6) begin
                pat = 4'b0001 << $urandom_range(0, 3);
            end else if (r == 7) begin
                pat = 4'($urandom_range(0, 15));
                while ($countones(pat) < 2) pat = 4'($urandom_range(0, 15));
            end else if (r == 8) begin
                pat = '0;
            end else begin
                pat = 4'b0001 << $urandom_range(0, 3);
                md  = 1'b1;
            end
            do_press(pat, hold, md, gap);
            check_state("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
